// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with clock filter, timeout and break/extended tagging
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       received_break,
    output logic       received_ext,
    output logic       frame_error
);

    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Two-flop synchronizers; idle bus level is high
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    // Clock glitch filter and edge detect
    logic          clk_flt_q, clk_flt_d;
    logic          clk_flt_prev_q;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_edge;

    // Frame FSM state and registered outputs
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    data_q;
    logic          en_q, brk_q, ext_q, err_q;
    logic          brk_pend_q, ext_pend_q;

    // Bring the asynchronous PS/2 lines into the CLOCK_50 domain
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DAT;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock only follows a new level held for FILTER_LEN cycles
    always_comb begin
        clk_flt_d = clk_flt_q;
        flt_cnt_d = '0;
        if (clk_s2_q != clk_flt_q) begin
            if (flt_cnt_q == FLT_MAX) begin
                clk_flt_d = clk_s2_q;
                flt_cnt_d = '0;
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
    end

    // Register filter state and the previous filtered level for edge detection
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            clk_flt_q      <= 1'b1;
            clk_flt_prev_q <= 1'b1;
            flt_cnt_q      <= '0;
        end else begin
            clk_flt_q      <= clk_flt_d;
            clk_flt_prev_q <= clk_flt_q;
            flt_cnt_q      <= flt_cnt_d;
        end
    end

    assign fall_edge = clk_flt_prev_q & ~clk_flt_q;

    // Frame FSM: shift bits on filtered falling edges, validate, tag prefixes, time out stalled frames
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
        end else begin
            en_q  <= 1'b0;
            err_q <= 1'b0;
            if (state_q != IDLE && !fall_edge && to_cnt_q == TO_MAX) begin
                state_q    <= IDLE;
                to_cnt_q   <= '0;
                err_q      <= 1'b1;
                brk_pend_q <= 1'b0;
                ext_pend_q <= 1'b0;
            end else begin
                if (state_q == IDLE || fall_edge) begin
                    to_cnt_q <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                end
                if (fall_edge) begin
                    case (state_q)
                        IDLE: begin
                            if (!dat_s2_q) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end
                        end
                        DATA: begin
                            shreg_q   <= {dat_s2_q, shreg_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= PARITY;
                            end
                        end
                        PARITY: begin
                            parity_q <= dat_s2_q;
                            state_q  <= STOP;
                        end
                        STOP: begin
                            state_q <= IDLE;
                            if (dat_s2_q && (^shreg_q ^ parity_q)) begin
                                data_q <= shreg_q;
                                en_q   <= 1'b1;
                                if (shreg_q == 8'hF0) begin
                                    brk_pend_q <= 1'b1;
                                    brk_q      <= 1'b0;
                                    ext_q      <= 1'b0;
                                end else if (shreg_q == 8'hE0) begin
                                    ext_pend_q <= 1'b1;
                                    brk_q      <= 1'b0;
                                    ext_q      <= 1'b0;
                                end else begin
                                    brk_q      <= brk_pend_q;
                                    ext_q      <= ext_pend_q;
                                    brk_pend_q <= 1'b0;
                                    ext_pend_q <= 1'b0;
                                end
                            end else begin
                                err_q      <= 1'b1;
                                brk_pend_q <= 1'b0;
                                ext_pend_q <= 1'b0;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign received_data    = data_q;
    assign received_data_en = en_q;
    assign received_break   = brk_q;
    assign received_ext     = ext_q;
    assign frame_error      = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - scoreboard bench for ps2_keyboard_rx with random scan-code frames
module tb_ps2_keyboard_rx;

    localparam int FL = 8;
    localparam int TO = 300;
    localparam int HP = 30;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       ps2c  = 1'b1;
    logic       ps2d  = 1'b1;
    logic [7:0] rdata;
    logic       ren, rbrk, rext, ferr;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50        (clk),
        .Reset           (rst),
        .PS2_CLK         (ps2c),
        .PS2_DAT         (ps2d),
        .received_data   (rdata),
        .received_data_en(ren),
        .received_break  (rbrk),
        .received_ext    (rext),
        .frame_error     (ferr)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] d;
        logic       b;
        logic       e;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad   = 0;
    logic       brk_p = 1'b0;
    logic       ext_p = 1'b0;
    logic [7:0] last_d = 8'h00;
    logic       prev_ev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        cyc(HP);
        ps2c = 1'b0;
        cyc(HP);
        ps2c = 1'b1;
    endtask

    // Reference model: a frame is good when stop=1 and parity is odd over data+parity
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        logic p;
        exp_t x;
        p = (~^d) ^ par_flip;
        if (!par_flip && stop) begin
            x.err = 1'b0;
            x.d   = d;
            if (d == 8'hF0) begin
                x.b = 1'b0; x.e = 1'b0; brk_p = 1'b1;
            end else if (d == 8'hE0) begin
                x.b = 1'b0; x.e = 1'b0; ext_p = 1'b1;
            end else begin
                x.b = brk_p; x.e = ext_p; brk_p = 1'b0; ext_p = 1'b0;
            end
            last_d = d;
        end else begin
            x.err = 1'b1; x.d = last_d; x.b = 1'b0; x.e = 1'b0;
            brk_p = 1'b0; ext_p = 1'b0;
        end
        q.push_back(x);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
        cyc(HP);
    endtask

    // Monitor: pop expectation on every strobe or error pulse
    always @(negedge clk) begin
        if (!rst && (ren || ferr)) begin
            chk("en_err_exclusive", {31'd0, ren && ferr}, 32'd0);
            chk("pulse_width", {31'd0, prev_ev}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event actual en=%0b err=%0b data=%0h required none", ren, ferr, rdata);
            end else begin
                mon_e = q.pop_front();
                chk("event_kind", {31'd0, ferr}, {31'd0, mon_e.err});
                chk("data", {24'd0, rdata}, {24'd0, mon_e.d});
                if (!mon_e.err) begin
                    chk("break", {31'd0, rbrk}, {31'd0, mon_e.b});
                    chk("ext", {31'd0, rext}, {31'd0, mon_e.e});
                end
            end
        end
        prev_ev <= ren || ferr;
    end

    initial begin
        int r;
        logic [7:0] d;
        cyc(4);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", {24'd0, rdata}, 32'd0);
        chk("rst_en", {31'd0, ren}, 32'd0);
        chk("rst_break", {31'd0, rbrk}, 32'd0);
        chk("rst_ext", {31'd0, rext}, 32'd0);
        chk("rst_err", {31'd0, ferr}, 32'd0);
        cyc(20);

        send_frame(8'h23, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        send_frame(8'h29, 1'b1, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);

        // Stall mid-frame: start plus four data bits, then silence
        begin
            exp_t x;
            x.err = 1'b1; x.d = last_d; x.b = 1'b0; x.e = 1'b0;
            brk_p = 1'b0; ext_p = 1'b0;
            q.push_back(x);
        end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2d = 1'b1;
        cyc(TO + 100);
        send_frame(8'h1C, 1'b0, 1'b1);

        // Short clock glitch with data low must not start a frame
        ps2d = 1'b0;
        cyc(5);
        ps2c = 1'b0;
        cyc(FL - 2);
        ps2c = 1'b1;
        cyc(40);
        ps2d = 1'b1;
        cyc(HP);
        send_frame(8'h23, 1'b0, 1'b1);

        // Reset in the middle of a frame discards it silently
        send_frame(8'hF0, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        brk_p = 1'b0; ext_p = 1'b0; last_d = 8'h00;
        @(negedge clk);
        chk("mid_reset_data", {24'd0, rdata}, 32'd0);
        ps2d = 1'b1;
        cyc(HP);
        send_frame(8'h23, 1'b0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            case (r)
                0: send_frame(8'hF0, 1'b0, 1'b1);
                1: send_frame(8'hE0, 1'b0, 1'b1);
                2: send_frame(d, 1'b1, 1'b1);
                3: send_frame(d, 1'b0, 1'b0);
                default: send_frame(d, 1'b0, 1'b1);
            endcase
        end
        ps2d = 1'b1;
        cyc(100);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receives PS/2 keyboard frames on the raw PS2_CLK/PS2_DAT lines and delivers validated scan-code bytes as `received_data` / `received_data_en`.
- The game-logic FSM consumes these byte strobes (0x23 D, 0x1C A, 0x29 Space).
- Also tags each byte with break (0xF0) and extended (0xE0) prefix status, so consumers can distinguish key release from key press.

Parameters:
- FILTER_LEN, 8: number of consecutive CLOCK_50 cycles PS2_CLK must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 100000: CLOCK_50 cycles (2 ms at 50 MHz) without a filtered falling edge, mid-frame, before the frame is aborted.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw keyboard clock, asynchronous.
- PS2_DAT  in  1  raw keyboard data, asynchronous.
- received_data  out  8  last valid byte.
- received_data_en  out  1  one-cycle strobe: received_data updated this cycle.
- received_break  out  1  current byte was preceded by 0xF0, valid with strobe.
- received_ext  out  1  current byte was preceded by 0xE0, valid with strobe.
- frame_error  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Reset: on a Reset-high clock edge, all outputs go to 0, state goes to IDLE, all counters clear, and prefix flags clear. The input synchronizer and filter preload to 1 (idle bus level).
- Synchronizer: PS2_CLK and PS2_DAT each pass through 2 flops.
- Clock filter: a counter runs while the synced clock differs from the filtered clock. The filtered clock takes the new value when the count reaches FILTER_LEN-1. The counter clears whenever the levels match. Pulses shorter than FILTER_LEN cycles are ignored.
- fall_edge: a one-cycle pulse when the filtered clock goes 1->0. Data is sampled from synced PS2_DAT in that same cycle.
- Frame format: 11 bits, sampled in this order:
  - start bit = 0
  - d0..d7, LSB first
  - odd parity
  - stop bit = 1
- FSM states and transitions:
  - IDLE: on fall_edge, go to DATA if data=0 (bit_cnt=0); if data=1, stay in IDLE (spurious edge).
  - DATA: each fall_edge shifts the bit into shreg[7] with a right shift and increments bit_cnt. Go to PARITY after the 8th bit.
  - PARITY: on fall_edge, latch the parity bit and go to STOP.
  - STOP: on fall_edge, the frame completes. The frame is valid when the stop bit is 1 and (^shreg ^ parity) == 1. Return to IDLE either way.
- Output timing: the frame-complete decision registers on the cycle after the stop-bit fall_edge.
  - Valid frame: received_data <= shreg and received_data_en = 1 for exactly one cycle.
  - Invalid frame: frame_error = 1 for one cycle, and received_data is unchanged.
- Prefix handling: every valid byte is output, including 0xF0 and 0xE0 themselves.
  - brk_pend is set by a valid 0xF0; ext_pend is set by a valid 0xE0.
  - On a valid byte that is neither 0xF0 nor 0xE0, received_break = brk_pend and received_ext = ext_pend are presented with the strobe, then both pend flags clear.
  - On the prefix bytes' own strobes, received_break = 0 and received_ext = 0.
  - An invalid frame clears both pend flags.
- Timeout: the timeout counter runs in any state other than IDLE and clears on every fall_edge.
  - Reaching TIMEOUT_CYCLES-1 forces IDLE, pulses frame_error, and clears the pend flags.
  - The counter width is sized to hold TIMEOUT_CYCLES.
- received_data, received_break and received_ext hold their values between strobes.
- received_data_en and frame_error are never asserted in the same cycle. Each is at most one cycle wide.
- Reset mid-frame: the partial frame is discarded with no strobe and no error. The next start bit is received normally.
- Back-to-back frames: IDLE accepts a new start bit on the first fall_edge after the output cycle. No dead time is required beyond the PS/2 bit time.

Test Plan:
- Frame 0x23 (start 0, bits 1,1,0,0,0,1,0,0, parity 0, stop 1) at 12 kHz -> received_data_en pulses once for 1 cycle, received_data=0x23, received_break=0, received_ext=0, frame_error stays 0.
- Frames 0xF0 then 0x1C -> two strobes: the first with data=0xF0 and break=0, the second with data=0x1C and break=1. A following 0x1C frame -> break=0.
- Frames 0xE0, 0xF0, 0x74 -> third strobe has data=0x74, break=1, ext=1.
- Frame 0x29 with parity bit flipped -> frame_error one-cycle pulse, no received_data_en, received_data keeps its prior value. Then a valid 0x29 -> strobe with 0x29.
- Send start plus 4 data bits, stop the clock for more than TIMEOUT_CYCLES -> frame_error pulse, FSM back in IDLE. Then a full 0x1C frame -> single strobe with 0x1C.
- PS2_CLK glitch of FILTER_LEN-2 cycles low while in IDLE -> no state change. Assert Reset for 1 cycle mid-frame, then send 0x23 -> exactly one strobe, 0x23, no frame_error.
